// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcodes, control-word bit positions,
// microstep encoding and a helper that tells whether an opcode has execute steps.
// Imported by the microcode decoder, the core top and the bench.
package sap_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Control-word bit indices
   localparam int CW_HLT = 0;
   localparam int CW_MI  = 1;
   localparam int CW_RI  = 2;
   localparam int CW_RO  = 3;
   localparam int CW_IO  = 4;
   localparam int CW_II  = 5;
   localparam int CW_AI  = 6;
   localparam int CW_AO  = 7;
   localparam int CW_EO  = 8;
   localparam int CW_SU  = 9;
   localparam int CW_BI  = 10;
   localparam int CW_OI  = 11;
   localparam int CW_CE  = 12;
   localparam int CW_CO  = 13;
   localparam int CW_J   = 14;
   localparam int CW_FI  = 15;
   localparam int CW_W   = 16;

   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

   // True when the instruction does something after fetch; otherwise it ends at T1.
   function automatic logic has_exec(input logic [3:0] op, input logic c, input logic z);
      case (op)
         OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_OUT, OP_HLT: has_exec = 1'b1;
         OP_JC:   has_exec = c;
         OP_JZ:   has_exec = z;
         default: has_exec = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sap_microcode.sv
// Microcode decoder: maps {opcode, step, C, Z} to the control word.
// Purely combinational; last_o flags the final microstep so the step counter resets early.
// No flow control of its own.
module sap_microcode
   import sap_pkg::*;
(
   input  logic [3:0]      opcode_i,
   input  step_t           step_i,
   input  logic            c_i,
   input  logic            z_i,
   output logic [CW_W-1:0] ctrl_o,
   output logic            last_o
);

   // Decode the control word and end-of-instruction marker for the current step
   always_comb begin
      ctrl_o = '0;
      last_o = 1'b0;
      case (step_i)
         T0: begin
            ctrl_o[CW_CO] = 1'b1;
            ctrl_o[CW_MI] = 1'b1;
         end
         T1: begin
            ctrl_o[CW_RO] = 1'b1;
            ctrl_o[CW_II] = 1'b1;
            ctrl_o[CW_CE] = 1'b1;
            last_o        = !has_exec(opcode_i, c_i, z_i);
         end
         T2: begin
            last_o = 1'b1;
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_MI] = 1'b1;
                  last_o        = 1'b0;
               end
               OP_LDI: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_AI] = 1'b1;
               end
               OP_JMP: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_J]  = 1'b1;
               end
               OP_JC: begin
                  ctrl_o[CW_IO] = c_i;
                  ctrl_o[CW_J]  = c_i;
               end
               OP_JZ: begin
                  ctrl_o[CW_IO] = z_i;
                  ctrl_o[CW_J]  = z_i;
               end
               OP_OUT: begin
                  ctrl_o[CW_AO] = 1'b1;
                  ctrl_o[CW_OI] = 1'b1;
               end
               OP_HLT:  ctrl_o[CW_HLT] = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            last_o = 1'b1;
            case (opcode_i)
               OP_LDA: begin
                  ctrl_o[CW_RO] = 1'b1;
                  ctrl_o[CW_AI] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl_o[CW_RO] = 1'b1;
                  ctrl_o[CW_BI] = 1'b1;
                  last_o        = 1'b0;
               end
               OP_STA: begin
                  ctrl_o[CW_AO] = 1'b1;
                  ctrl_o[CW_RI] = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            last_o = 1'b1;
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               ctrl_o[CW_EO] = 1'b1;
               ctrl_o[CW_AI] = 1'b1;
               ctrl_o[CW_FI] = 1'b1;
               ctrl_o[CW_SU] = (opcode_i == OP_SUB);
            end
         end
         default: last_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/sap_core.sv
// SAP computer core: PC, MAR, RAM, IR, A/B, ALU, output register and microstep sequencer.
// One microstep per tick (divider in run mode, step rising edge otherwise); no ticks once halted.
// Programming port writes RAM on any clock and overrides a simultaneous RI write.
module sap_core
   import sap_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int TICK_DIV = 2**24,
   localparam int ADDR_W   = DATA_W - 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_value,
   output logic              out_valid,
   output logic              halted,
   output logic [1:0]        flags,
   output logic [DATA_W-1:0] bus_dbg,
   output logic [ADDR_W-1:0] pc_dbg
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int DIV_W = $clog2(TICK_DIV);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] pc_q, pc_d, mar_q;
   logic [DATA_W-1:0] ir_q, a_q, b_q, out_q;
   logic              c_q, z_q, halted_q, out_vld_q, step_edge_q;
   step_t             step_q, step_d;
   logic [DIV_W-1:0]  div_q, div_d;

   logic              tick, div_hit, last_step;
   logic [3:0]        opcode;
   logic [CW_W-1:0]   ctrl;
   logic [DATA_W-1:0] ram_rd, bus, b_op;
   logic [DATA_W:0]   sum;

   assign ram_rd = mem[mar_q];

   // Microstep tick: divider in run mode, step rising edge otherwise, never when halted
   always_comb begin
      div_hit = (div_q == DIV_W'(TICK_DIV - 1));
      div_d   = '0;
      if (run && !div_hit) div_d = div_q + 1'b1;
      tick = !halted_q && (run ? div_hit : (step && !step_edge_q));
   end

   // At T1 the IR is only being loaded, so decode the early-reset decision from the fetched word
   assign opcode = (step_q == T1) ? ram_rd[DATA_W-1 -: 4] : ir_q[DATA_W-1 -: 4];

   sap_microcode u_microcode (
      .opcode_i (opcode),
      .step_i   (step_q),
      .c_i      (c_q),
      .z_i      (z_q),
      .ctrl_o   (ctrl),
      .last_o   (last_step)
   );

   // ALU: subtraction is A + ~B + 1 so the carry reads as "no borrow"
   always_comb begin
      b_op = ctrl[CW_SU] ? ~b_q : b_q;
      sum  = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, ctrl[CW_SU]};
   end

   // Internal bus: one-hot source select, zero when idle
   always_comb begin
      bus = '0;
      if (ctrl[CW_CO])      bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      else if (ctrl[CW_RO]) bus = ram_rd;
      else if (ctrl[CW_IO]) bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
      else if (ctrl[CW_AO]) bus = a_q;
      else if (ctrl[CW_EO]) bus = sum[DATA_W-1:0];
   end

   // Next PC and next microstep
   always_comb begin
      pc_d = pc_q;
      if (ctrl[CW_J])       pc_d = bus[ADDR_W-1:0];
      else if (ctrl[CW_CE]) pc_d = pc_q + 1'b1;
      step_d = last_step ? T0 : step_t'(step_q + 3'd1);
   end

   // Architectural registers, updated only on ticks (divider and edge detector every clk)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= '0;
         mar_q       <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_q       <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         halted_q    <= 1'b0;
         out_vld_q   <= 1'b0;
         step_edge_q <= 1'b0;
         step_q      <= T0;
         div_q       <= '0;
      end else begin
         div_q       <= div_d;
         step_edge_q <= step;
         out_vld_q   <= tick && ctrl[CW_OI];
         if (tick) begin
            pc_q   <= pc_d;
            step_q <= step_d;
            if (ctrl[CW_MI])  mar_q    <= bus[ADDR_W-1:0];
            if (ctrl[CW_II])  ir_q     <= bus;
            if (ctrl[CW_AI])  a_q      <= bus;
            if (ctrl[CW_BI])  b_q      <= bus;
            if (ctrl[CW_OI])  out_q    <= bus;
            if (ctrl[CW_HLT]) halted_q <= 1'b1;
            if (ctrl[CW_FI]) begin
               c_q <= sum[DATA_W];
               z_q <= (sum[DATA_W-1:0] == '0);
            end
         end
      end
   end

   // RAM: not reset; programming port takes priority over an RI write
   always_ff @(posedge clk) begin
      if (prog_we)                 mem[prog_addr] <= prog_data;
      else if (tick && ctrl[CW_RI]) mem[mar_q]     <= bus;
   end

   assign out_value = out_q;
   assign out_valid = out_vld_q;
   assign halted    = halted_q;
   assign flags     = {c_q, z_q};
   assign bus_dbg   = bus;
   assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core: small programs in run and single-step mode,
// hand-computed results for A, flags, PC, out_value, RAM and reset behaviour.
module tb_sap_core;
   import sap_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run = 1'b0;
   logic              step = 1'b0;
   logic              prog_we = 1'b0;
   logic [ADDR_W-1:0] prog_addr = '0;
   logic [DATA_W-1:0] prog_data = '0;
   logic [DATA_W-1:0] out_value;
   logic              out_valid;
   logic              halted;
   logic [1:0]        flags;
   logic [DATA_W-1:0] bus_dbg;
   logic [ADDR_W-1:0] pc_dbg;

   int errors = 0;
   int checks = 0;
   int ov_cnt = 0;
   logic [DATA_W-1:0] img [16];

   sap_core #(.DATA_W(DATA_W), .TICK_DIV(2)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .out_value(out_value), .out_valid(out_valid), .halted(halted),
      .flags(flags), .bus_dbg(bus_dbg), .pc_dbg(pc_dbg)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (out_valid === 1'b1) ov_cnt++;

   task automatic apply_reset;
      @(negedge clk);
      rst = 1'b1; run = 1'b0; step = 1'b0; prog_we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_img;
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
   endtask

   task automatic load_img;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic pulse_step;
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_to_halt(input string name);
      int n = 0;
      run = 1'b1;
      while (halted !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout halted=%b want 1", name, halted);
      end
   endtask

   task automatic test_reset;
      apply_reset();
      checks++; if (pc_dbg !== 4'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_dbg); end
      checks++; if (out_value !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%b want 00/0", out_value, out_valid); end
      checks++; if (halted !== 1'b0 || flags !== 2'b00) begin errors++; $display("FAIL reset_status got halted=%b flags=%b want 0/00", halted, flags); end
      checks++; if (dut.step_q !== T0 || dut.a_q !== 8'h00) begin errors++; $display("FAIL reset_step_a got %0d/%h want 0/00", dut.step_q, dut.a_q); end
   endtask

   task automatic test_lda_add_out;
      int base;
      apply_reset();
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
      img[14] = 8'h1C; img[15] = 8'h0E;
      load_img();
      base = ov_cnt;
      run_to_halt("prog1");
      checks++; if (out_value !== 8'h2A) begin errors++; $display("FAIL prog1_out got %h want 2a", out_value); end
      checks++; if (ov_cnt - base !== 1) begin errors++; $display("FAIL prog1_pulses got %0d want 1", ov_cnt - base); end
      checks++; if (flags !== 2'b00) begin errors++; $display("FAIL prog1_flags got %b want 00", flags); end
      repeat (20) @(negedge clk);
      checks++; if (pc_dbg !== 4'h4 || dut.step_q !== T0) begin errors++; $display("FAIL prog1_frozen got pc=%h step=%0d want 4/0", pc_dbg, dut.step_q); end
      checks++; if (ov_cnt - base !== 1) begin errors++; $display("FAIL prog1_no_more_out got %0d want 1", ov_cnt - base); end
      run = 1'b0;
   endtask

   task automatic test_sub_jz;
      int base;
      // SUB equal -> C=1 Z=1, JZ taken to OUT at 8
      apply_reset();
      clear_img();
      img[0] = 8'h55; img[1] = 8'h3F; img[2] = 8'h88; img[3] = 8'hF0;
      img[8] = 8'hE0; img[9] = 8'hF0; img[15] = 8'h05;
      load_img();
      base = ov_cnt;
      run_to_halt("jz_taken");
      checks++; if (flags !== 2'b11) begin errors++; $display("FAIL jz_taken_flags got %b want 11", flags); end
      checks++; if (out_value !== 8'h00 || ov_cnt - base !== 1) begin errors++; $display("FAIL jz_taken_out got %h pulses=%0d want 00/1", out_value, ov_cnt - base); end
      checks++; if (pc_dbg !== 4'hA) begin errors++; $display("FAIL jz_taken_pc got %h want a", pc_dbg); end
      run = 1'b0;
      // SUB borrow -> A=FF, C=0 Z=0, JZ falls through (stepped)
      apply_reset();
      img[15] = 8'h06;
      load_img();
      base = ov_cnt;
      repeat (10) pulse_step();
      checks++; if (pc_dbg !== 4'h3 || dut.step_q !== T0) begin errors++; $display("FAIL jz_fall_pc got pc=%h step=%0d want 3/0", pc_dbg, dut.step_q); end
      checks++; if (dut.a_q !== 8'hFF || flags !== 2'b00) begin errors++; $display("FAIL jz_fall_alu got a=%h flags=%b want ff/00", dut.a_q, flags); end
      run_to_halt("jz_fall");
      checks++; if (pc_dbg !== 4'h4 || ov_cnt - base !== 0) begin errors++; $display("FAIL jz_fall_end got pc=%h pulses=%0d want 4/0", pc_dbg, ov_cnt - base); end
      run = 1'b0;
   endtask

   task automatic test_add_carry;
      apply_reset();
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hF0;
      img[14] = 8'hFF; img[15] = 8'h01;
      load_img();
      run_to_halt("carry");
      checks++; if (dut.a_q !== 8'h00 || flags !== 2'b11) begin errors++; $display("FAIL carry_result got a=%h flags=%b want 00/11", dut.a_q, flags); end
      run = 1'b0;
   endtask

   task automatic test_single_step;
      apply_reset();
      clear_img();
      img[0] = 8'h53; img[1] = 8'hF0;
      load_img();
      pulse_step();
      checks++; if (dut.step_q !== T1) begin errors++; $display("FAIL step1 got %0d want 1", dut.step_q); end
      pulse_step();
      checks++; if (dut.step_q !== T2 || dut.a_q !== 8'h00) begin errors++; $display("FAIL step2 got step=%0d a=%h want 2/00", dut.step_q, dut.a_q); end
      pulse_step();
      checks++; if (dut.step_q !== T0 || dut.a_q !== 8'h03) begin errors++; $display("FAIL step3 got step=%0d a=%h want 0/03", dut.step_q, dut.a_q); end
      @(negedge clk) step = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (dut.step_q !== T1 || pc_dbg !== 4'h1) begin errors++; $display("FAIL step_held got step=%0d pc=%h want 1/1", dut.step_q, pc_dbg); end
      step = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_jmp_wrap;
      apply_reset();
      clear_img();
      img[0] = 8'h6F; img[15] = 8'h00;
      load_img();
      repeat (3) pulse_step();
      checks++; if (pc_dbg !== 4'hF) begin errors++; $display("FAIL jmp_pc got %h want f", pc_dbg); end
      repeat (2) pulse_step();
      checks++; if (pc_dbg !== 4'h0 || dut.step_q !== T0) begin errors++; $display("FAIL wrap_pc got pc=%h step=%0d want 0/0", pc_dbg, dut.step_q); end
   endtask

   task automatic test_reset_midrun;
      apply_reset();
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[14] = 8'h1C; img[15] = 8'h0E;
      load_img();
      repeat (7) pulse_step();
      checks++; if (dut.step_q !== T3 || dut.a_q !== 8'h1C) begin errors++; $display("FAIL pre_rst got step=%0d a=%h want 3/1c", dut.step_q, dut.a_q); end
      #2 rst = 1'b1;
      #1;
      checks++; if (pc_dbg !== 4'h0 || dut.mar_q !== 4'h0 || dut.ir_q !== 8'h00) begin errors++; $display("FAIL rst_mid_regs got pc=%h mar=%h ir=%h want 0/0/00", pc_dbg, dut.mar_q, dut.ir_q); end
      checks++; if (dut.a_q !== 8'h00 || dut.b_q !== 8'h00 || dut.step_q !== T0) begin errors++; $display("FAIL rst_mid_ab got a=%h b=%h step=%0d want 00/00/0", dut.a_q, dut.b_q, dut.step_q); end
      checks++; if (out_value !== 8'h00 || halted !== 1'b0 || flags !== 2'b00) begin errors++; $display("FAIL rst_mid_status got %h/%b/%b want 00/0/00", out_value, halted, flags); end
      checks++; if (dut.mem[14] !== 8'h1C || dut.mem[15] !== 8'h0E) begin errors++; $display("FAIL rst_mid_ram got %h/%h want 1c/0e", dut.mem[14], dut.mem[15]); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_prog_vs_sta;
      // Plain STA stores A
      apply_reset();
      clear_img();
      img[0] = 8'h57; img[1] = 8'h4C; img[2] = 8'hF0;
      load_img();
      run_to_halt("sta");
      checks++; if (dut.mem[12] !== 8'h07) begin errors++; $display("FAIL sta_store got %h want 07", dut.mem[12]); end
      run = 1'b0;
      // Programming write on the RI tick wins
      apply_reset();
      load_img();
      repeat (6) pulse_step();
      @(negedge clk);
      step = 1'b1; prog_we = 1'b1; prog_addr = 4'hC; prog_data = 8'hA5;
      @(negedge clk);
      step = 1'b0; prog_we = 1'b0;
      @(negedge clk);
      checks++; if (dut.mem[12] !== 8'hA5 || dut.step_q !== T0) begin errors++; $display("FAIL prog_wins got mem=%h step=%0d want a5/0", dut.mem[12], dut.step_q); end
   endtask

   initial begin
      test_reset();
      test_lda_add_out();
      test_sub_jz();
      test_add_carry();
      test_single_step();
      test_jmp_wrap();
      test_reset_midrun();
      test_prog_vs_sta();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
